dsp_mac_pipe: RTL and testbench
===============================

# dsp_mac_pipe

Parametrised multiply-accumulate pipeline for the DSP datapath, generalising the DSP48A1 slice: configurable operand and accumulator widths, selectable multiplier register, signed arithmetic, an optional saturating post-adder with overflow flag, and a valid-tagged pipeline so accumulation chains stay correct under stalls. It sits between the sample source and downstream filter/accumulator logic, and is used wherever the fixed 18x18/48 slice is too rigid.

## Interface
- AW, 18: width of A (signed)
- BW, 18: width of B and D (signed); pre-adder result wraps to BW bits
- PW, 48: width of C, P; must be >= AW+BW
- MREG, 1: 1 = registered multiplier stage; 0 = stage removed
- SAT, 0: 1 = saturate post-adder on signed overflow; 0 = wrap

- CLK  in  1  clock; all registers update on rising edge
- RST  in  1  synchronous, active-high reset; overrides CE
- CE  in  1  pipeline enable; 0 freezes every stage
- IN_VALID  in  1  input sample valid; sampled only when CE=1
- A  in  AW  multiplier operand
- B  in  BW  pre-adder/multiplier operand
- D  in  BW  pre-adder operand
- C  in  PW  post-adder operand
- USE_PRE  in  1  1: mult operand = pre-adder result; 0: = B
- PRE_SUB  in  1  pre-adder: 0 = D+B, 1 = D-B
- ZSEL  in  2  post-adder Z: 0 = zero, 1 = P feedback, 2 = C, 3 = zero
- SUB  in  1  post-adder: 0 = Z+(M+CIN), 1 = Z-(M+CIN)
- CIN  in  1  carry-in
- P  out  PW  result
- P_VALID  out  1  P holds a new result this cycle
- CARRYOUT  out  1  unsigned carry/borrow of post-add
- OVF  out  1  signed overflow of the result currently on P

## Operation
- Stage 1 (always): register A, pre-adder result (wrapped to BW), C, ZSEL, SUB, CIN, IN_VALID as a bundle.
- Stage 2 (MREG=1): register M = signed A × stage-1 operand, AW+BW bits; with MREG=0 product feeds stage 3 combinationally.
- Stage 3 (always): M sign-extended to PW; compute Z ± (M+CIN) at PW+1 bits; register P, CARRYOUT, OVF, P_VALID.
- Stage 3 updates P/CARRYOUT/OVF only when its incoming valid bit is 1; otherwise all hold and P_VALID=0.
- ZSEL=1 uses the current P register, so back-to-back valid accumulates each add exactly once; bubbles do not accumulate.
- Control fields travel with their data; changing ZSEL/SUB mid-stream affects only samples accepted after the change.
- CARRYOUT: bit PW of unsigned (PW+1)-bit Z + (M+CIN) for SUB=0; for SUB=1, 1 = no borrow (Z >= M+CIN unsigned).
- OVF: 1 when the true signed result exceeds PW-bit range. SAT=1: P clamps to 2^(PW-1)-1 or -2^(PW-1). SAT=0: P wraps.

## Timing
- Latency IN_VALID→P_VALID: 2+MREG enabled cycles (3 by default); throughput 1 sample/cycle.
- CE=0: no register changes, P_VALID held at its current value; pipeline resumes exactly where frozen, no loss or duplication.
- RST=1 at a rising edge: all data, control and valid registers cleared; P=0, P_VALID=0, CARRYOUT=0, OVF=0 next cycle; in-flight samples dropped; RST wins over CE=0.
- Input accepted with RST=1 is discarded.
- P_VALID is a one-cycle pulse per accepted sample (level held only if CE drops).

## Test plan
- Reset: RST=1 for 2 cycles with random inputs, IN_VALID=1 → P=0, P_VALID=0, CARRYOUT=0, OVF=0; first P_VALID exactly 3 cycles after RST drops with IN_VALID=1.
- Pre-add path: A=3, B=5, D=10, USE_PRE=1, PRE_SUB=0, ZSEL=2, C=100, CIN=1 → P=146, P_VALID high 3 cycles later for one cycle; same with PRE_SUB=1, SUB=1 → P=100-(15+1)=84.
- Accumulate: one sample ZSEL=0 then three ZSEL=1, A=2, B=7, USE_PRE=0 on consecutive cycles → P=14, 28, 42, 56; inserting a bubble (IN_VALID=0) leaves P at 28 for that cycle.
- Stall: CE=0 for 3 cycles mid accumulate chain → all outputs frozen; after resume the sequence completes 14, 28, 42, 56 with no repeats.
- Overflow/carry: C=2^47-1, ZSEL=2, A=1, B=1 → SAT=1: P=2^47-1, OVF=1; SAT=0: P=-2^47, OVF=1. C=-1 (all ones), A=1, B=1, SUB=0 → P=0, CARRYOUT=1, OVF=0.
- Reset mid-operation: assert RST one cycle while 3 samples in flight → P=0 next cycle, none of the 3 results ever appear; MREG=0 build repeats scenarios with latency 2.

Source files
------------

// File: rtl/dsp_mac_pipe_if.sv
// rtl/dsp_mac_pipe_if.sv - operand/control inputs and result outputs of the MAC pipeline
interface dsp_mac_pipe_if #(
  parameter int AW = 18,
  parameter int BW = 18,
  parameter int PW = 48
);
  logic                 ce;
  logic                 in_valid;
  logic signed [AW-1:0] a;
  logic signed [BW-1:0] b;
  logic signed [BW-1:0] d;
  logic        [PW-1:0] c;
  logic                 use_pre;
  logic                 pre_sub;
  logic        [1:0]    zsel;
  logic                 sub;
  logic                 cin;
  logic        [PW-1:0] p;
  logic                 p_valid;
  logic                 carryout;
  logic                 ovf;

  modport master (
    output ce, in_valid, a, b, d, c, use_pre, pre_sub, zsel, sub, cin,
    input  p, p_valid, carryout, ovf
  );

  modport slave (
    input  ce, in_valid, a, b, d, c, use_pre, pre_sub, zsel, sub, cin,
    output p, p_valid, carryout, ovf
  );
endinterface

// File: rtl/dsp_mac_pipe.sv
// rtl/dsp_mac_pipe.sv - signed pre-add / multiply / post-add pipeline with valid tagging
module dsp_mac_pipe #(
  parameter int AW   = 18,
  parameter int BW   = 18,
  parameter int PW   = 48,
  parameter int MREG = 1,
  parameter int SAT  = 0
) (
  input logic           clk,
  input logic           rst,
  dsp_mac_pipe_if.slave bus
);
  localparam int MW = AW + BW;

  logic signed [BW-1:0] pre_sum;
  logic signed [BW-1:0] op_sel;

  always_comb begin
    pre_sum = bus.pre_sub ? (bus.d - bus.b) : (bus.d + bus.b);
    op_sel  = bus.use_pre ? pre_sum : bus.b;
  end

  logic signed [AW-1:0] s1_a;
  logic signed [BW-1:0] s1_op;
  logic        [PW-1:0] s1_c;
  logic        [1:0]    s1_zsel;
  logic                 s1_sub;
  logic                 s1_cin;
  logic                 s1_vld;

  // control fields ride alongside their data so mid-stream changes stay sample-aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_a    <= '0;
      s1_op   <= '0;
      s1_c    <= '0;
      s1_zsel <= '0;
      s1_sub  <= 1'b0;
      s1_cin  <= 1'b0;
      s1_vld  <= 1'b0;
    end else if (bus.ce) begin
      s1_a    <= bus.a;
      s1_op   <= op_sel;
      s1_c    <= bus.c;
      s1_zsel <= bus.zsel;
      s1_sub  <= bus.sub;
      s1_cin  <= bus.cin;
      s1_vld  <= bus.in_valid;
    end
  end

  logic signed [MW-1:0] prod;
  assign prod = MW'(s1_a) * MW'(s1_op);

  logic signed [MW-1:0] s2_m;
  logic        [PW-1:0] s2_c;
  logic        [1:0]    s2_zsel;
  logic                 s2_sub;
  logic                 s2_cin;
  logic                 s2_vld;

  generate
    if (MREG != 0) begin : g_mreg
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_m    <= '0;
          s2_c    <= '0;
          s2_zsel <= '0;
          s2_sub  <= 1'b0;
          s2_cin  <= 1'b0;
          s2_vld  <= 1'b0;
        end else if (bus.ce) begin
          s2_m    <= prod;
          s2_c    <= s1_c;
          s2_zsel <= s1_zsel;
          s2_sub  <= s1_sub;
          s2_cin  <= s1_cin;
          s2_vld  <= s1_vld;
        end
      end
    end else begin : g_comb
      always_comb begin
        s2_m    = prod;
        s2_c    = s1_c;
        s2_zsel = s1_zsel;
        s2_sub  = s1_sub;
        s2_cin  = s1_cin;
        s2_vld  = s1_vld;
      end
    end
  endgenerate

  logic [PW-1:0] p_q;
  logic          pv_q;
  logic          co_q;
  logic          ovf_q;

  logic [PW:0]   z_x;
  logic [PW:0]   m_x;
  logic [PW:0]   sum_x;
  logic [PW-1:0] p_n;
  logic          co_n;
  logic          ovf_n;

  // one guard bit on top of PW makes the signed overflow test a simple top-two-bit compare
  always_comb begin
    case (s2_zsel)
      2'd1:    z_x = {p_q[PW-1], p_q};
      2'd2:    z_x = {s2_c[PW-1], s2_c};
      default: z_x = '0;
    endcase
    m_x   = (PW+1)'(s2_m) + (PW+1)'(s2_cin);
    sum_x = s2_sub ? (z_x - m_x) : (z_x + m_x);
    // unsigned add carries exactly when z > ~m; subtract reports "no borrow"
    co_n  = s2_sub ? (z_x[PW-1:0] >= m_x[PW-1:0]) : (z_x[PW-1:0] > ~m_x[PW-1:0]);
    ovf_n = sum_x[PW] ^ sum_x[PW-1];
    p_n   = sum_x[PW-1:0];
    if ((SAT != 0) && ovf_n) begin
      p_n = sum_x[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q   <= '0;
      pv_q  <= 1'b0;
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (bus.ce) begin
      pv_q <= s2_vld;
      if (s2_vld) begin
        p_q   <= p_n;
        co_q  <= co_n;
        ovf_q <= ovf_n;
      end
    end
  end

  assign bus.p        = p_q;
  assign bus.p_valid  = pv_q;
  assign bus.carryout = co_q;
  assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb/tb_dsp_mac_pipe.sv - scoreboard bench running an MREG=1/SAT=1 and an MREG=0/SAT=0 instance in lockstep
module tb_dsp_mac_pipe;
  localparam int AW = 18;
  localparam int BW = 18;
  localparam int PW = 48;

  typedef struct {
    logic [PW-1:0] p;
    logic          co;
    logic          ovf;
    int            tag;
  } exp_t;

  logic                 clk      = 1'b0;
  logic                 rst      = 1'b1;
  logic                 ce       = 1'b1;
  logic                 in_valid = 1'b0;
  logic signed [AW-1:0] a        = '0;
  logic signed [BW-1:0] b        = '0;
  logic signed [BW-1:0] d        = '0;
  logic        [PW-1:0] c        = '0;
  logic                 use_pre  = 1'b0;
  logic                 pre_sub  = 1'b0;
  logic        [1:0]    zsel     = '0;
  logic                 sub      = 1'b0;
  logic                 cin      = 1'b0;

  int   total = 0;
  int   bad   = 0;
  int   ecnt  = 0;
  logic en_q  = 1'b0;
  exp_t q1[$];
  exp_t q0[$];

  always #5 clk = ~clk;

  dsp_mac_pipe_if #(.AW(AW), .BW(BW), .PW(PW)) if1 ();
  dsp_mac_pipe_if #(.AW(AW), .BW(BW), .PW(PW)) if0 ();

  assign if1.ce = ce;           assign if0.ce = ce;
  assign if1.in_valid = in_valid; assign if0.in_valid = in_valid;
  assign if1.a = a;             assign if0.a = a;
  assign if1.b = b;             assign if0.b = b;
  assign if1.d = d;             assign if0.d = d;
  assign if1.c = c;             assign if0.c = c;
  assign if1.use_pre = use_pre; assign if0.use_pre = use_pre;
  assign if1.pre_sub = pre_sub; assign if0.pre_sub = pre_sub;
  assign if1.zsel = zsel;       assign if0.zsel = zsel;
  assign if1.sub = sub;         assign if0.sub = sub;
  assign if1.cin = cin;         assign if0.cin = cin;

  dsp_mac_pipe #(.AW(AW), .BW(BW), .PW(PW), .MREG(1), .SAT(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  dsp_mac_pipe #(.AW(AW), .BW(BW), .PW(PW), .MREG(0), .SAT(0)) u0 (.clk(clk), .rst(rst), .bus(if0));

  // enabled-edge counter: a result is due a fixed number of enabled edges after issue
  always @(posedge clk) begin
    en_q <= ce | rst;
    if (ce | rst) ecnt <= ecnt + 1;
  end

  task automatic chk(input string nm, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic cmp_out(input string nm, input exp_t e, input logic [PW-1:0] p,
                         input logic co, input logic ov);
    chk({nm, "_p"}, p, e.p);
    chk({nm, "_carryout"}, PW'(co), PW'(e.co));
    chk({nm, "_ovf"}, PW'(ov), PW'(e.ovf));
    chk({nm, "_latency"}, PW'(ecnt), PW'(e.tag));
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (en_q && if1.p_valid === 1'b1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL u1_unexpected_p_valid got p=%0h exp=none", if1.p);
      end else begin
        e = q1.pop_front();
        cmp_out("u1", e, if1.p, if1.carryout, if1.ovf);
      end
    end
    if (en_q && if0.p_valid === 1'b1) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL u0_unexpected_p_valid got p=%0h exp=none", if0.p);
      end else begin
        e = q0.pop_front();
        cmp_out("u0", e, if0.p, if0.carryout, if0.ovf);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic issue(input int av, input int bv, input int dv, input logic [PW-1:0] cv,
                       input logic up, input logic ps, input logic [1:0] zs, input logic sb,
                       input logic ci,
                       input logic [PW-1:0] p1, input logic c1, input logic o1,
                       input logic [PW-1:0] p0, input logic c0, input logic o0);
    a = AW'(av); b = BW'(bv); d = BW'(dv); c = cv;
    use_pre = up; pre_sub = ps; zsel = zs; sub = sb; cin = ci;
    in_valid = 1'b1;
    q1.push_back('{p: p1, co: c1, ovf: o1, tag: ecnt + 3});
    q0.push_back('{p: p0, co: c0, ovf: o0, tag: ecnt + 2});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic acc(input logic [1:0] zs, input logic [PW-1:0] ev);
    issue(2, 7, 0, '0, 1'b0, 1'b0, zs, 1'b0, 1'b0, ev, 1'b0, 1'b0, ev, 1'b0, 1'b0);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_u1_p"}, if1.p, '0);
    chk({nm, "_u1_p_valid"}, PW'(if1.p_valid), '0);
    chk({nm, "_u1_carryout"}, PW'(if1.carryout), '0);
    chk({nm, "_u1_ovf"}, PW'(if1.ovf), '0);
    chk({nm, "_u0_p"}, if0.p, '0);
    chk({nm, "_u0_p_valid"}, PW'(if0.p_valid), '0);
    chk({nm, "_u0_carryout"}, PW'(if0.carryout), '0);
    chk({nm, "_u0_ovf"}, PW'(if0.ovf), '0);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; in_valid = 1'b1;
    repeat (2) begin
      a = AW'($urandom); b = BW'($urandom); d = BW'($urandom);
      c = {16'($urandom), 32'($urandom)}; zsel = 2'($urandom);
      tick();
    end
    check_zero("reset");
    rst = 1'b0;
    in_valid = 1'b0;

    issue(3, 5, 10, 48'd100, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 48'd146, 1'b0, 1'b0, 48'd146, 1'b0, 1'b0);
    idle(4);
    issue(3, 5, 10, 48'd100, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 48'd84, 1'b1, 1'b0, 48'd84, 1'b1, 1'b0);
    idle(4);

    acc(2'd0, 48'd14); acc(2'd1, 48'd28); acc(2'd1, 48'd42); acc(2'd1, 48'd56);
    idle(4);

    acc(2'd0, 48'd14); acc(2'd1, 48'd28); idle(1); acc(2'd1, 48'd42); acc(2'd1, 48'd56);
    idle(4);

    // freeze mid-chain: u0 already shows 14, u1 still shows the previous chain's 56
    acc(2'd0, 48'd14); acc(2'd1, 48'd28);
    ce = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("stall_u0_p", if0.p, 48'd14);
      chk("stall_u0_p_valid", PW'(if0.p_valid), 48'd1);
      chk("stall_u1_p", if1.p, 48'd56);
      chk("stall_u1_p_valid", PW'(if1.p_valid), 48'd0);
      a = AW'($urandom); b = BW'($urandom); zsel = 2'($urandom);
      if (i < 3) tick();
    end
    ce = 1'b1;
    in_valid = 1'b0;
    acc(2'd1, 48'd42); acc(2'd1, 48'd56);
    idle(4);

    issue(1, 1, 0, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0,
          48'h7FFF_FFFF_FFFF, 1'b0, 1'b1, 48'h8000_0000_0000, 1'b0, 1'b1);
    issue(1, 1, 0, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0,
          48'h0, 1'b1, 1'b0, 48'h0, 1'b1, 1'b0);
    issue(1, 1, 0, 48'h8000_0000_0000, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0,
          48'h8000_0000_0000, 1'b1, 1'b1, 48'h7FFF_FFFF_FFFF, 1'b1, 1'b1);
    idle(4);

    // reset lands while samples are in flight; the third sample arrives with rst high
    issue(100, 100, 0, '0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 48'd10000, 1'b0, 1'b0, 48'd10000, 1'b0, 1'b0);
    issue(100, 100, 0, '0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 48'd20000, 1'b0, 1'b0, 48'd20000, 1'b0, 1'b0);
    a = AW'(100); b = BW'(100); zsel = 2'd1; in_valid = 1'b1; rst = 1'b1;
    tick();
    q1.delete();
    q0.delete();
    rst = 1'b0;
    in_valid = 1'b0;
    check_zero("midrst");
    idle(6);

    issue(3, 5, 10, 48'd100, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 48'd146, 1'b0, 1'b0, 48'd146, 1'b0, 1'b0);
    idle(6);

    chk("u1_queue_drained", PW'(q1.size()), '0);
    chk("u0_queue_drained", PW'(q0.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
